// File: rtl/pipe_adder_pkg.sv
// Shared types and constants for the pipelined adder.
// Build option: PIPE_ADDER_SAT_EN enables signed saturation of the result.
package pipe_adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int chunk_w(input int width, input int stages);
        return width / stages;
    endfunction

    // Per-stage control; operand and sum slices are sized per stage.
    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctl_t;

endpackage

// File: rtl/pipe_adder_slice.sv
// Combinational ripple-carry slice; also exposes the carry into its MSB.
// Build option: none.
module add_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         c_msb_in
);

    logic [W:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < W; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    assign co       = c[W];
    assign c_msb_in = c[W-1];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/sub: one CHUNK-bit carry slice resolved per stage.
// Build option: PIPE_ADDER_SAT_EN saturates the sum on signed overflow.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK = chunk_w(WIDTH, STAGES);

    logic advance;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int WIN = WIDTH - k * CHUNK;
        localparam int WLO = (k + 1) * CHUNK;

        logic [WIN-1:0]   src_a;
        logic [WIN-1:0]   src_b;
        logic             src_c;
        logic             src_v;
        logic [WLO-1:0]   n_raw;
        logic [WLO-1:0]   n_sum;
        logic [WLO-1:0]   r_sum;
        logic [CHUNK-1:0] s;
        logic             co;
        logic             c_msb;
        stage_ctl_t       r_ctl;

        if (k == 0) begin : g_first
            assign src_a = a;
            assign src_b = (sub == OP_SUB) ? ~b : b;
            assign src_c = (sub == OP_SUB) ? 1'b1 : cin;
            assign src_v = in_valid;
            assign n_raw = s;
        end else begin : g_next
            assign src_a = g_st[k-1].g_fwd.r_a;
            assign src_b = g_st[k-1].g_fwd.r_b;
            assign src_c = g_st[k-1].r_ctl.carry;
            assign src_v = g_st[k-1].r_ctl.valid;
            assign n_raw = {s, g_st[k-1].r_sum};
        end

        add_slice #(
            .W(CHUNK)
        ) u_slice (
            .x        (src_a[CHUNK-1:0]),
            .y        (src_b[CHUNK-1:0]),
            .ci       (src_c),
            .s        (s),
            .co       (co),
            .c_msb_in (c_msb)
        );

        if (k < STAGES - 1) begin : g_fwd
            logic [WIN-CHUNK-1:0] r_a;
            logic [WIN-CHUNK-1:0] r_b;
            logic                 unused_cmsb;

            assign unused_cmsb = c_msb;
            assign n_sum       = n_raw;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (advance) begin
                    r_a <= src_a[WIN-1:CHUNK];
                    r_b <= src_b[WIN-1:CHUNK];
                end
            end
        end else begin : g_last
            logic ovf_n;
            logic r_ovf;

            assign ovf_n = c_msb ^ co;
`ifdef PIPE_ADDER_SAT_EN
            // No carry out on overflow means two positives wrapped negative.
            always_comb begin
                n_sum = n_raw;
                if (ovf_n) begin
                    n_sum = co ? {1'b1, {(WLO-1){1'b0}}}
                               : {1'b0, {(WLO-1){1'b1}}};
                end
            end
`else
            assign n_sum = n_raw;
`endif

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ovf <= 1'b0;
                end else if (advance) begin
                    r_ovf <= ovf_n;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_ctl <= '0;
                r_sum <= '0;
            end else if (advance) begin
                r_ctl.valid <= src_v;
                r_ctl.carry <= co;
                r_sum       <= n_sum;
            end
        end
    end

    assign out_valid = g_st[STAGES-1].r_ctl.valid;
    assign cout      = g_st[STAGES-1].r_ctl.carry;
    assign sum       = g_st[STAGES-1].r_sum;
    assign ovf       = g_st[STAGES-1].g_last.r_ovf;

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder against an arithmetic reference model.
// Build option: PIPE_ADDER_SAT_EN switches the model to saturating sums.
module tb_pipe_adder;

    localparam int W   = 32;
    localparam int STG = 4;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           cyc;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    beat_t exp_q[$];
    beat_t obs_q[$];

    pipe_adder #(
        .WIDTH  (W),
        .STAGES (STG)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready)
            obs_q.push_back('{sum, cout, ovf, cyc});
    end

    // Reference: full-precision unsigned and signed arithmetic.
    function automatic beat_t model(input logic [W-1:0] va, input logic [W-1:0] vb,
                                    input logic vc, input logic vs);
        beat_t  r;
        longint sa;
        longint sb;
        longint sr;
        longint ua;
        longint ub;
        sa = longint'($signed(va));
        sb = longint'($signed(vb));
        ua = longint'(va);
        ub = longint'(vb);
        if (vs) begin
            r.sum  = va - vb;
            r.cout = (ua >= ub);
            sr     = sa - sb;
        end else begin
            r.sum  = va + vb + W'(vc);
            r.cout = ((ua + ub + longint'(vc)) >= 64'h1_0000_0000);
            sr     = sa + sb + longint'(vc);
        end
        r.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
`ifdef PIPE_ADDER_SAT_EN
        if (r.ovf) r.sum = (sr > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
        r.cyc = 0;
        return r;
    endfunction

    task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vc, input logic vs);
        beat_t e;
        bit    done;
        done     = 0;
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        cin      = vc;
        sub      = vs;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                e     = model(va, vb, vc, vs);
                e.cyc = cyc;
                exp_q.push_back(e);
                done  = 1;
            end
            @(posedge clk);
            #2;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout in_ready=%b required=1", in_ready);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic wait_obs(input int n);
        for (int t = 0; t < 200 && obs_q.size() < n; t++) begin
            @(posedge clk);
            #2;
        end
        if (obs_q.size() < n) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got=%0d required=%0d", obs_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got=%b required=0", out_valid);
        end
        checks++;
        if ({sum, cout, ovf} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h/%b/%b required=0/0/0", sum, cout, ovf);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got=%b required=1", in_ready);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic test_add();
        exp_q.delete();
        obs_q.delete();
        send(32'h5, 32'h2, 1'b0, 1'b0);
        idle();
        wait_obs(1);
        if (obs_q.size() >= 1) begin
            checks++;
            if ({obs_q[0].sum, obs_q[0].cout, obs_q[0].ovf} !== {32'h7, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL add_basic got=%h/%b/%b required=00000007/0/0",
                         obs_q[0].sum, obs_q[0].cout, obs_q[0].ovf);
            end
            checks++;
            if (obs_q[0].cyc - exp_q[0].cyc !== STG) begin
                errors++;
                $display("FAIL add_latency got=%0d required=%0d",
                         obs_q[0].cyc - exp_q[0].cyc, STG);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_q.delete();
        obs_q.delete();
        send(32'h0000_000F, 32'h0000_FFFF, 1'b0, 1'b0);
        send(32'h0000_0008, 32'h0000_0005, 1'b1, 1'b0);
        send(32'h1000_0FFF, 32'h0000_FFFF, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++)
            send($urandom, $urandom, 1'($urandom), 1'($urandom));
        idle();
        wait_obs(8);
        checks++;
        if (exp_q[0].sum !== 32'h0001_000E || exp_q[1].sum !== 32'h0000_000E ||
            exp_q[2].sum !== 32'h1001_0FFF) begin
            errors++;
            $display("FAIL b2b_model got=%h/%h/%h required=0001000e/0000000e/10010fff",
                     exp_q[0].sum, exp_q[1].sum, exp_q[2].sum);
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if ({obs_q[i].sum, obs_q[i].cout, obs_q[i].ovf} !==
                {exp_q[i].sum, exp_q[i].cout, exp_q[i].ovf}) begin
                errors++;
                $display("FAIL b2b_data[%0d] got=%h/%b/%b required=%h/%b/%b", i,
                         obs_q[i].sum, obs_q[i].cout, obs_q[i].ovf,
                         exp_q[i].sum, exp_q[i].cout, exp_q[i].ovf);
            end
            checks++;
            if (obs_q[i].cyc !== exp_q[i].cyc + STG) begin
                errors++;
                $display("FAIL b2b_timing[%0d] got=%0d required=%0d", i,
                         obs_q[i].cyc, exp_q[i].cyc + STG);
            end
        end
    endtask

    task automatic test_sub_ovf();
        exp_q.delete();
        obs_q.delete();
        send(32'h5, 32'h2, 1'b0, 1'b1);
        send(32'h2, 32'h5, 1'b1, 1'b1);
        send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
        send(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
        send(32'h8000_0000, 32'h1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++)
            send($urandom, $urandom, 1'($urandom), 1'b1);
        idle();
        wait_obs(11);
        checks++;
        if ({exp_q[0].sum, exp_q[0].cout, exp_q[1].sum, exp_q[1].cout,
             exp_q[3].sum, exp_q[3].cout, exp_q[3].ovf} !==
            {32'h3, 1'b1, 32'hFFFF_FFFD, 1'b0, 32'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL sub_model got=%h/%b %h/%b required=00000003/1 fffffffd/0",
                     exp_q[0].sum, exp_q[0].cout, exp_q[1].sum, exp_q[1].cout);
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if ({obs_q[i].sum, obs_q[i].cout, obs_q[i].ovf} !==
                {exp_q[i].sum, exp_q[i].cout, exp_q[i].ovf}) begin
                errors++;
                $display("FAIL sub_ovf[%0d] got=%h/%b/%b required=%h/%b/%b", i,
                         obs_q[i].sum, obs_q[i].cout, obs_q[i].ovf,
                         exp_q[i].sum, exp_q[i].cout, exp_q[i].ovf);
            end
        end
    endtask

    task automatic test_backpressure();
        exp_q.delete();
        obs_q.delete();
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send($urandom, $urandom, 1'($urandom), 1'($urandom));
                idle();
            end
            begin
                repeat (5) @(posedge clk);
                #2;
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    checks++;
                    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL hold_handshake got=%b/%b required=0/1",
                                 in_ready, out_valid);
                    end
                    checks++;
                    if (obs_q.size() >= exp_q.size() ||
                        sum !== exp_q[obs_q.size()].sum) begin
                        errors++;
                        $display("FAIL hold_sum got=%h obs=%0d exp=%0d",
                                 sum, obs_q.size(), exp_q.size());
                    end
                end
                @(posedge clk);
                #2;
                out_ready = 1'b1;
            end
        join
        wait_obs(6);
        checks++;
        if (obs_q.size() !== 6) begin
            errors++;
            $display("FAIL bp_count got=%0d required=6", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if ({obs_q[i].sum, obs_q[i].cout, obs_q[i].ovf} !==
                {exp_q[i].sum, exp_q[i].cout, exp_q[i].ovf}) begin
                errors++;
                $display("FAIL bp_data[%0d] got=%h/%b/%b required=%h/%b/%b", i,
                         obs_q[i].sum, obs_q[i].cout, obs_q[i].ovf,
                         exp_q[i].sum, exp_q[i].cout, exp_q[i].ovf);
            end
        end
    endtask

    task automatic test_random_stall();
        exp_q.delete();
        obs_q.delete();
        fork
            begin
                for (int i = 0; i < 25; i++)
                    send($urandom, $urandom, 1'($urandom), 1'($urandom));
                idle();
            end
            begin
                repeat (60) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #2;
                end
                out_ready = 1'b1;
            end
        join
        wait_obs(25);
        checks++;
        if (obs_q.size() !== 25) begin
            errors++;
            $display("FAIL rnd_count got=%0d required=25", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if ({obs_q[i].sum, obs_q[i].cout, obs_q[i].ovf} !==
                {exp_q[i].sum, exp_q[i].cout, exp_q[i].ovf}) begin
                errors++;
                $display("FAIL rnd_data[%0d] got=%h/%b/%b required=%h/%b/%b", i,
                         obs_q[i].sum, obs_q[i].cout, obs_q[i].ovf,
                         exp_q[i].sum, exp_q[i].cout, exp_q[i].ovf);
            end
        end
    endtask

    task automatic test_reset_midflight();
        exp_q.delete();
        obs_q.delete();
        for (int i = 0; i < 3; i++)
            send($urandom, $urandom, 1'($urandom), 1'($urandom));
        idle();
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_flush_valid got=%b required=0", out_valid);
        end
        repeat (8) begin
            @(posedge clk);
            #2;
        end
        checks++;
        if (obs_q.size() !== 0) begin
            errors++;
            $display("FAIL rst_stale got=%0d required=0", obs_q.size());
        end
        send(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);
        idle();
        wait_obs(1);
        if (obs_q.size() >= 1) begin
            checks++;
            if ({obs_q[0].sum, obs_q[0].cout, obs_q[0].ovf} !==
                {32'h2222_2222, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL rst_fresh got=%h/%b/%b required=22222222/0/0",
                         obs_q[0].sum, obs_q[0].cout, obs_q[0].ovf);
            end
            checks++;
            if (obs_q[0].cyc - exp_q[0].cyc !== STG) begin
                errors++;
                $display("FAIL rst_fresh_latency got=%0d required=%0d",
                         obs_q[0].cyc - exp_q[0].cyc, STG);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_add();
        test_back_to_back();
        test_sub_ovf();
        test_backpressure();
        test_random_stall();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
